cdb_arbiter: RTL and testbench

- Shares NUM_CDB common-data-bus broadcast ports among NUM_REQ functional-unit result streams (add, mul, div, br).
- Sits between execute and the ROB, regfile and reservation stations.
- Each requester has a one-entry holding buffer; grants are round-robin.
- Back-pressure goes to issue via per-requester ready. The whole buffer is cleared on a pipeline flush.

---
 rtl/cdb_arbiter.sv | 110 +++++++++++
 tb/tb_cdb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin sharing of NUM_CDB broadcast ports among NUM_REQ one-entry FU result buffers; broadcast >=1 cycle
// after accept, per-requester ready stalls issue. Define CDB_BR_PRIORITY_EN to grant the branch unit first.
package cdb_pkg;
   typedef struct packed {
      logic        valid;
      logic [5:0]  rob_idx;
      logic [31:0] rd_v;
      logic        pc_select;
      logic [31:0] pc_branch;
   } cdb_t;
endpackage

module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_CDB = 2,
   parameter int BR_IDX  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  cdb_t [NUM_REQ-1:0]           req_cdb,
   output logic [NUM_REQ-1:0]           req_ready,
   output cdb_t [NUM_CDB-1:0]           cdb_out,
   output logic [NUM_REQ-1:0]           grant,
   output logic [$clog2(NUM_REQ+1)-1:0] occupancy
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int OW = $clog2(NUM_REQ+1);
`ifdef CDB_BR_PRIORITY_EN
   localparam bit BR_PRIO = 1'b1;
`else
   localparam bit BR_PRIO = 1'b0;
`endif
   localparam logic [NUM_REQ-1:0] BR_BIT  = NUM_REQ'(1) << BR_IDX;
   localparam logic [NUM_REQ-1:0] RR_MASK = BR_PRIO ? ~BR_BIT : '1;

   logic [NUM_REQ-1:0] buf_v;
   cdb_t [NUM_REQ-1:0] buf_d;
   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      rr_next;
   logic [NUM_REQ-1:0] gnt;
   cdb_t [NUM_CDB-1:0] port_d;

   // Grants depend only on registered buffers, so req_cdb never reaches cdb_out in the same cycle.
   always_comb begin : arb
      int n;
      n       = 0;
      gnt     = '0;
      port_d  = '0;
      rr_next = rr_ptr;
      if (BR_PRIO && buf_v[BR_IDX]) begin
         gnt[BR_IDX] = 1'b1;
         port_d[0]   = buf_d[BR_IDX];
         n           = 1;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i == (int'(rr_ptr) + k) % NUM_REQ && buf_v[i] && RR_MASK[i] && n < NUM_CDB) begin
               gnt[i] = 1'b1;
               for (int j = 0; j < NUM_CDB; j++) begin
                  if (j == n) port_d[j] = buf_d[i];
               end
               rr_next = PW'((i + 1) % NUM_REQ);
               n       = n + 1;
            end
         end
      end
   end

   always_comb begin
      grant     = '0;
      cdb_out   = '0;
      req_ready = '0;
      occupancy = '0;
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) occupancy = occupancy + OW'(buf_v[i]);
         if (flush) begin
            req_ready = '1;
         end else begin
            grant     = gnt;
            cdb_out   = port_d;
            req_ready = ~buf_v | gnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_v  <= '0;
         rr_ptr <= '0;
      end else if (flush) begin
         buf_v <= '0;
      end else begin
         // A branch-only grant leaves rr_next at rr_ptr, so the pointer only moves on round-robin grants.
         if (|grant) rr_ptr <= rr_next;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_cdb[i].valid && req_ready[i]) begin
               buf_v[i] <= 1'b1;
               buf_d[i] <= req_cdb[i];
            end else if (grant[i]) begin
               buf_v[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector table for arbitration order, flush and reset, then random traffic against a result scoreboard.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int NR = 4;
   localparam int NC = 2;
`ifdef CDB_BR_PRIORITY_EN
   localparam int LATMAX = 3;
`else
   localparam int LATMAX = 2;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   cdb_t [NR-1:0]     req_cdb;
   logic [NR-1:0]     req_ready;
   cdb_t [NC-1:0]     cdb_out;
   logic [NR-1:0]     grant;
   logic [2:0]        occupancy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic       rn, fl;
      logic [3:0] vm;
      int         tag;
      logic [3:0] g, rdy;
      int         occ;
      logic       v0;
      int         s0, t0;
      logic       v1;
      int         s1, t1;
   } vec_t;

   typedef struct {
      int   idx;
      cdb_t d;
      int   cyc;
   } sb_t;

   vec_t tv[$];
   sb_t  sb[$];
   cdb_t hold[NR];
   int   seq = 0;

   cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC), .BR_IDX(3)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req_cdb(req_cdb), .req_ready(req_ready),
      .cdb_out(cdb_out), .grant(grant), .occupancy(occupancy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic cdb_t mk(input int i, input int tag);
      cdb_t c;
      c           = '0;
      c.valid     = 1'b1;
      c.rob_idx   = {i[1:0], tag[3:0]};
      c.rd_v      = {16'hC0DE, i[7:0], tag[7:0]};
      c.pc_select = tag[0];
      c.pc_branch = {i[7:0], tag[7:0], 16'h5A5A};
      return c;
   endfunction

   function automatic vec_t mkv(input logic rn, input logic fl, input logic [3:0] vm, input int tag,
                                input logic [3:0] g, input logic [3:0] rdy, input int occ,
                                input logic v0, input int s0, input int t0,
                                input logic v1, input int s1, input int t1);
      vec_t v;
      v.rn = rn; v.fl = fl; v.vm = vm; v.tag = tag; v.g = g; v.rdy = rdy; v.occ = occ;
      v.v0 = v0; v.s0 = s0; v.t0 = t0; v.v1 = v1; v.s1 = s1; v.t1 = t1;
      return v;
   endfunction

   function automatic cdb_t rnd_res(input int i);
      cdb_t c;
      c           = '0;
      c.valid     = 1'b1;
      c.rob_idx   = 6'($urandom);
      c.rd_v      = {i[3:0], 28'(seq)};
      c.pc_select = 1'($urandom);
      c.pc_branch = $urandom;
      seq++;
      return c;
   endfunction

   task automatic rand_cycle(input bit gen, input bit allow_fl);
      logic [NR-1:0] pend, bc, exp_rdy;
      logic [NC-1:0] vmask, exp_vmask;
      int  np, nv, exp_nv, k, lat;
      bit  fl;
      @(posedge clk); #1;
      fl    = allow_fl && ($urandom_range(0, 19) == 0);
      flush = fl;
      for (int i = 0; i < NR; i++) req_cdb[i] = hold[i];
      #1;
      pend = '0;
      foreach (sb[e]) pend[sb[e].idx] = 1'b1;
      np = sb.size();
      bc = '0; vmask = '0; nv = 0;
      for (int j = 0; j < NC; j++) begin
         if (cdb_out[j].valid) begin
            vmask[j] = 1'b1;
            nv++;
            k = -1;
            foreach (sb[e]) if (sb[e].d == cdb_out[j]) k = e;
            checks++;
            if (k < 0) begin
               errors++;
               $display("FAIL rand_unknown_port%0d act=%0h required=a_pending_result", j, cdb_out[j]);
            end else begin
               bc[sb[k].idx] = 1'b1;
               lat = cyc - sb[k].cyc;
               chk("rand_latency", lat >= 1 && lat <= LATMAX, 1);
               sb.delete(k);
            end
         end
      end
      exp_nv    = fl ? 0 : (np < NC ? np : NC);
      exp_vmask = NC'((1 << nv) - 1);
      chk("rand_nports", nv, exp_nv);
      chk("rand_port_order", vmask, exp_vmask);
      chk("rand_grant", grant, bc);
      chk("rand_occ", occupancy, np);
      exp_rdy = fl ? '1 : (~pend | bc);
      chk("rand_ready", req_ready, exp_rdy);
      if (fl) begin
         sb.delete();
      end else begin
         foreach (sb[e]) chk("rand_overdue", (cyc - sb[e].cyc) < LATMAX, 1);
      end
      for (int i = 0; i < NR; i++) begin
         if (hold[i].valid && !fl && exp_rdy[i]) sb.push_back('{idx: i, d: hold[i], cyc: cyc});
         if (!hold[i].valid || (!fl && exp_rdy[i]))
            hold[i] = (gen && $urandom_range(0, 9) < 6) ? rnd_res(i) : '0;
      end
   endtask

   initial begin
      cdb_t exp0, exp1;
      rst = 1'b0; flush = 1'b0; req_cdb = '0;
      for (int i = 0; i < NR; i++) hold[i] = '0;
      //                rst fl  vm      tag grant   ready   occ  port0        port1
      tv.push_back(mkv(0, 0, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b1111, 2, 4'b0000, 4'b1111, 0, 0, 0, 0,  0, 0, 0));
`ifndef CDB_BR_PRIORITY_EN
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b0011, 4'b0011, 4, 1, 0, 2,  1, 1, 2));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b1100, 4'b1111, 2, 1, 2, 2,  1, 3, 2));
      tv.push_back(mkv(1, 0, 4'b1111, 3, 4'b0000, 4'b1111, 0, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b0010, 4, 4'b0011, 4'b0011, 4, 1, 0, 3,  1, 1, 3));
      tv.push_back(mkv(1, 0, 4'b0010, 5, 4'b1100, 4'b1101, 3, 1, 2, 3,  1, 3, 3));
      tv.push_back(mkv(1, 0, 4'b0010, 5, 4'b0010, 4'b1111, 1, 1, 1, 4,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b0010, 4'b1111, 1, 1, 1, 5,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b0111, 6, 4'b0000, 4'b1111, 0, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 1, 4'b1111, 7, 4'b0000, 4'b1111, 3, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b1111, 8, 4'b0000, 4'b1111, 0, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b1100, 4'b1100, 4, 1, 2, 8,  1, 3, 8));
      tv.push_back(mkv(1, 0, 4'b1100, 9, 4'b0011, 4'b1111, 2, 1, 0, 8,  1, 1, 8));
      tv.push_back(mkv(0, 0, 4'b1111, 10, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b1111, 11, 4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b0011, 4'b0011, 4, 1, 0, 11, 1, 1, 11));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b1100, 4'b1111, 2, 1, 2, 11, 1, 3, 11));
      tv.push_back(mkv(1, 0, 4'b1011, 12, 4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b0011, 4'b0111, 3, 1, 0, 12, 1, 1, 12));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b1000, 4'b1111, 1, 1, 3, 12, 0, 0, 0));
`else
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b1001, 4'b1001, 4, 1, 3, 2,  1, 0, 2));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b0110, 4'b1111, 2, 1, 1, 2,  1, 2, 2));
      tv.push_back(mkv(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b1011, 3, 4'b0000, 4'b1111, 0, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b1000, 4, 4'b1001, 4'b1101, 3, 1, 3, 3,  1, 0, 3));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b1010, 4'b1111, 2, 1, 3, 4,  1, 1, 3));
      tv.push_back(mkv(1, 0, 4'b0111, 5, 4'b0000, 4'b1111, 0, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 1, 4'b1111, 6, 4'b0000, 4'b1111, 3, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b1111, 7, 4'b0000, 4'b1111, 0, 0, 0, 0,  0, 0, 0));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b1100, 4'b1100, 4, 1, 3, 7,  1, 2, 7));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b0011, 4'b1111, 2, 1, 0, 7,  1, 1, 7));
      tv.push_back(mkv(1, 0, 4'b0000, 0, 4'b0000, 4'b1111, 0, 0, 0, 0,  0, 0, 0));
`endif
      repeat (2) @(posedge clk);

      foreach (tv[r]) begin
         @(posedge clk); #1;
         rst   = tv[r].rn;
         flush = tv[r].fl;
         for (int i = 0; i < NR; i++) req_cdb[i] = tv[r].vm[i] ? mk(i, tv[r].tag) : '0;
         #1;
         exp0 = tv[r].v0 ? mk(tv[r].s0, tv[r].t0) : '0;
         exp1 = tv[r].v1 ? mk(tv[r].s1, tv[r].t1) : '0;
         chk($sformatf("row%0d_grant", r), grant, tv[r].g);
         chk($sformatf("row%0d_ready", r), req_ready, tv[r].rdy);
         chk($sformatf("row%0d_occ", r), occupancy, tv[r].occ);
         chk($sformatf("row%0d_port0", r), cdb_out[0], exp0);
         chk($sformatf("row%0d_port1", r), cdb_out[1], exp1);
      end

      // Single result from the add unit: broadcast the following cycle on port 0.
      @(posedge clk); #1;
      rst = 1'b1; flush = 1'b0; req_cdb = '0;
      req_cdb[0].valid = 1'b1; req_cdb[0].rob_idx = 6'd5; req_cdb[0].rd_v = 32'h1234;
      #1;
      chk("single_ready", req_ready[0], 1'b1);
      chk("single_occ_before", occupancy, 0);
      @(posedge clk); #1;
      req_cdb = '0;
      #1;
      chk("single_valid", cdb_out[0].valid, 1'b1);
      chk("single_rob_idx", cdb_out[0].rob_idx, 6'd5);
      chk("single_rd_v", cdb_out[0].rd_v, 32'h1234);
      chk("single_port1_idle", cdb_out[1], 0);
      chk("single_grant", grant, 4'b0001);
      chk("single_occ_during", occupancy, 1);
      @(posedge clk); #2;
      chk("single_occ_after", occupancy, 0);
      chk("single_grant_after", grant, 4'b0000);

      repeat (400) rand_cycle(1'b1, 1'b1);
      repeat (8) rand_cycle(1'b0, 1'b0);
      chk("drain_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
